// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 burst slave over an internal dual-port word SRAM, independent read/write FSMs
// Define AXI_SLV_ADDR_ERR_EN to drop out-of-range beats and answer them with SLVERR.
module axi_sram_slave #(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                LEN_W     = 8,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ID_W-1:0]     awid_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [LEN_W-1:0]    awlen_i,
  input  logic [2:0]          awsize_i,
  input  logic [1:0]          awburst_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wlast_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [ID_W-1:0]     bid_o,
  output logic [2:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  input  logic [ID_W-1:0]     arid_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic [LEN_W-1:0]    arlen_i,
  input  logic [2:0]          arsize_i,
  input  logic [1:0]          arburst_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [ID_W-1:0]     rid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [2:0]          rresp_o,
  output logic                rlast_o,
  output logic                rvalid_o,
  input  logic                rready_i
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [LEN_W-1:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]        wburst_q, wburst_d;
  logic              werr_q, werr_d;

  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]        rburst_q, rburst_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word_q;
  logic              mem_we, mem_re;

  logic [ADDR_W-1:0] woff, roff;
  logic [IDX_W-1:0]  widx, ridx;
  logic              woob, roob;

  assign woff = waddr_q - BASE_ADDR;
  assign roff = raddr_q - BASE_ADDR;
  assign widx = woff[IDX_W+1:2];
  assign ridx = roff[IDX_W+1:2];

`ifdef AXI_SLV_ADDR_ERR_EN
  // Offsets below BASE_ADDR wrap to large values, so one compare covers both ends.
  localparam int                SPAN_W = ADDR_W + 1;
  localparam logic [SPAN_W-1:0] SPAN   = SPAN_W'(4 * DEPTH);
  assign woob = ({1'b0, woff} >= SPAN);
  assign roob = ({1'b0, roff} >= SPAN);
`else
  assign woob = 1'b0;
  assign roob = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{awsize_i, arsize_i, wlast_i, woff, roff};

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wburst_d  = wburst_q;
    werr_d    = werr_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          wid_d     = awid_i;
          waddr_d   = awaddr_i;
          wlen_d    = awlen_i;
          wburst_d  = awburst_i;
          wcnt_d    = '0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready_o = 1'b1;
        // Burst length comes from AWLEN alone; WLAST is not trusted.
        if (wvalid_i) begin
          mem_we = !woob;
          werr_d = werr_q | woob;
          if (wcnt_q == wlen_q) begin
            w_state_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q + LEN_W'(1);
            if (wburst_q != 2'd0) waddr_d = waddr_q + ADDR_W'(4);
          end
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign bid_o   = wid_q;
  assign bresp_o = (bvalid_o && werr_q) ? 3'd2 : 3'd0;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rburst_d  = rburst_q;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    mem_re    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) begin
          rid_d     = arid_i;
          raddr_d   = araddr_i;
          rlen_d    = arlen_i;
          rburst_d  = arburst_i;
          rcnt_d    = '0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        mem_re    = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        if (rready_i) begin
          if (rcnt_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            rcnt_d    = rcnt_q + LEN_W'(1);
            if (rburst_q != 2'd0) raddr_d = raddr_q + ADDR_W'(4);
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign rid_o   = rid_q;
  assign rlast_o = rvalid_o && (rcnt_q == rlen_q);
  assign rresp_o = (rvalid_o && roob) ? 3'd2 : 3'd0;
  assign rdata_o = (rvalid_o && !roob) ? rd_word_q : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rburst_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rburst_q  <= rburst_d;
    end
  end

  // Both ports update with non-blocking writes, so a same-word read sees the old data.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < DATA_W/8; k++) begin
        if (wstrb_i[k]) mem_q[widx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (mem_re) rd_word_q <= mem_q[ridx];
  end

endmodule
